fetch_queue_unit: RTL and testbench

Parametrised instruction fetch front end that decouples instruction-memory access from the decode stage. It issues sequential fetch requests over a ready/valid memory interface and buffers returned instructions with their PC+4 in a DEPTH-entry queue. Decode drains the queue under its stall signal and redirects fetch on taken branches and jumps. It sits between the instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_queue_unit_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch_queue_unit.sv | 111 +++++++++++
 tb/tb_fetch_queue_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional feature macro used by the top: FETCH_STATS_EN.
package fetch_queue_unit_pkg;

   // One buffered instruction together with the address of its successor
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } fq_entry_t;

   localparam int unsigned FQ_DEPTH  = 4;
   localparam int unsigned FQ_PTR_W  = $clog2(FQ_DEPTH);
   localparam logic [31:0] FQ_PC_INC = 32'd4;

   // Pointer width for an arbitrary (power-of-two) queue depth
   function automatic int unsigned fq_ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched instructions: push, pop, flush, occupancy
// count, and a head read straight from the storage flops.
module fetch_queue
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned   DEPTH = FQ_DEPTH,
   localparam int unsigned  PTR_W = fq_ptr_w(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  fq_entry_t        i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [PTR_W:0]   o_count,
   output logic             o_head_valid,
   output fq_entry_t        o_head
);

   fq_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_valid;
   logic             w_pop;

   assign w_valid = (r_count != '0);
   // Never pop an empty queue; overflow is prevented upstream by the credit rule
   assign w_pop   = i_pop && w_valid;

   // Storage, pointers and count; flush wins over push and pop
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count      = r_count;
   assign o_head_valid = w_valid;
   assign o_head       = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: sequential fetch over a ready/valid memory
// port, buffering of returned instructions, redirect on taken branches.
// Optional macro FETCH_STATS_EN adds redirect and empty-cycle counters.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int unsigned   DEPTH    = FQ_DEPTH,
   parameter logic [31:0]   RESET_PC = 32'h0000_0000,
   localparam int unsigned  PTR_W    = fq_ptr_w(DEPTH)
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        ID_PCSrc,
   input  logic [31:0] ID_new_PC,
   input  logic        ID_stall,
   output logic        IM_Req,
   output logic [31:0] IM_Addr,
   input  logic        IM_Ready,
   input  logic [31:0] IM_RData,
   output logic        IF_Valid,
   output logic [31:0] IF_Instruction,
   output logic [31:0] IF_PC4
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] FS_Redirects,
   output logic [31:0] FS_EmptyCycles
`endif
);

   logic [31:0] r_pc;
   logic        r_inflight;

   logic [PTR_W:0] w_count;
   logic           w_credit;
   logic           w_accept;
   logic           w_kill;
   logic           w_push;
   logic           w_pop;
   fq_entry_t      w_push_data;
   fq_entry_t      w_head;

   // Outstanding request reserves a slot so a full queue can never overflow
   assign w_credit = (32'(w_count) + 32'(r_inflight)) < DEPTH;
   assign IM_Req   = !Reset && !ID_PCSrc && w_credit;
   assign IM_Addr  = r_pc;
   assign w_accept = IM_Req && IM_Ready;

   // A redirect kills the response landing this cycle; the flush also drops it
   assign w_kill   = ID_PCSrc;
   assign w_push   = r_inflight && !w_kill;
   assign w_pop    = IF_Valid && !ID_stall && !ID_PCSrc;

   // r_pc has already stepped past the in-flight address, so it is that address + 4
   assign w_push_data = '{instr: IM_RData, pc4: r_pc};

   // Fetch PC and in-flight tracking
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_pc       <= RESET_PC;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept;
         if (ID_PCSrc) begin
            r_pc <= ID_new_PC;
         end else if (w_accept) begin
            r_pc <= r_pc + FQ_PC_INC;
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk        (Clk),
      .i_rst        (Reset),
      .i_push       (w_push),
      .i_push_data  (w_push_data),
      .i_pop        (w_pop),
      .i_flush      (ID_PCSrc),
      .o_count      (w_count),
      .o_head_valid (IF_Valid),
      .o_head       (w_head)
   );

   assign IF_Instruction = w_head.instr;
   assign IF_PC4         = w_head.pc4;

`ifdef FETCH_STATS_EN
   logic [31:0] r_fs_redirects;
   logic [31:0] r_fs_empty;

   // Saturating counters of redirects and decode-starved cycles
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fs_redirects <= '0;
         r_fs_empty     <= '0;
      end else begin
         if (ID_PCSrc && (r_fs_redirects != '1)) begin
            r_fs_redirects <= r_fs_redirects + 32'd1;
         end
         if (!IF_Valid && !ID_stall && (r_fs_empty != '1)) begin
            r_fs_empty <= r_fs_empty + 32'd1;
         end
      end
   end

   assign FS_Redirects   = r_fs_redirects;
   assign FS_EmptyCycles = r_fs_empty;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a directed vector table followed by hand
// sequences and randomized traffic checked against a queue-based model.
module tb_fetch_queue_unit;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        ID_PCSrc = 1'b0;
   logic [31:0] ID_new_PC = '0;
   logic        ID_stall = 1'b0;
   logic        IM_Req;
   logic [31:0] IM_Addr;
   logic        IM_Ready = 1'b1;
   logic [31:0] IM_RData = '0;
   logic        IF_Valid;
   logic [31:0] IF_Instruction;
   logic [31:0] IF_PC4;
`ifdef FETCH_STATS_EN
   logic [31:0] FS_Redirects;
   logic [31:0] FS_EmptyCycles;
`endif

   fetch_queue_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .ID_PCSrc       (ID_PCSrc),
      .ID_new_PC      (ID_new_PC),
      .ID_stall       (ID_stall),
      .IM_Req         (IM_Req),
      .IM_Addr        (IM_Addr),
      .IM_Ready       (IM_Ready),
      .IM_RData       (IM_RData),
      .IF_Valid       (IF_Valid),
      .IF_Instruction (IF_Instruction),
`ifdef FETCH_STATS_EN
      .IF_PC4         (IF_PC4),
      .FS_Redirects   (FS_Redirects),
      .FS_EmptyCycles (FS_EmptyCycles)
`else
      .IF_PC4         (IF_PC4)
`endif
   );

   always #5 Clk = ~Clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Memory side: acceptance seen before the edge, data returned after it
   logic        acc;
   logic [31:0] acc_addr;

   // Reference model state
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc = RESET_PC;
   bit          m_pend = 1'b0;
   logic [31:0] m_pend_addr = '0;
   int unsigned m_redir = 0;
   int unsigned m_empty = 0;

   typedef struct {
      logic        rst;
      logic        pcsrc;
      logic [31:0] npc;
      logic        stall;
      logic        ready;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc4;
      logic        zero_head;
   } vec_t;
   vec_t tbl[20];

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a ^ 32'h5A3C_0F11) + 32'h0000_1357;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic pcsrc, input logic [31:0] npc,
                        input logic stall, input logic ready);
      Reset     = rst;
      ID_PCSrc  = pcsrc;
      ID_new_PC = npc;
      ID_stall  = stall;
      IM_Ready  = ready;
   endtask

   task automatic next_cycle();
      acc      = IM_Req && IM_Ready;
      acc_addr = IM_Addr;
      @(posedge Clk);
      #1;
      IM_RData = acc ? instr_of(acc_addr) : $urandom;
   endtask

   // One cycle against the model: compare, advance the model, clock
   task automatic model_cycle(input logic rst, input logic pcsrc, input logic [31:0] npc,
                              input logic stall, input logic ready);
      bit exp_req;
      bit exp_valid;
      drive(rst, pcsrc, npc, stall, ready);
      #2;
      exp_valid = !rst && (mq.size() != 0);
      exp_req   = !rst && !pcsrc && ((mq.size() + int'(m_pend)) < int'(DEPTH));
      check("im_req", 32'(IM_Req), 32'(exp_req));
      check("im_addr", IM_Addr, rst ? RESET_PC : m_pc);
      check("if_valid", 32'(IF_Valid), 32'(exp_valid));
      if (exp_valid) begin
         check("if_instr", IF_Instruction, mq[0].instr);
         check("if_pc4", IF_PC4, mq[0].pc4);
      end
      if (rst) begin
         check("rst_instr", IF_Instruction, 32'h0);
         check("rst_pc4", IF_PC4, 32'h0);
      end
      check("count_bound", 32'(32'(dut.u_queue.o_count) <= DEPTH), 32'd1);
`ifdef FETCH_STATS_EN
      check("fs_redirects", FS_Redirects, rst ? 32'd0 : m_redir);
      check("fs_empty", FS_EmptyCycles, rst ? 32'd0 : m_empty);
`endif
      if (rst) begin
         mq.delete();
         m_pc    = RESET_PC;
         m_pend  = 1'b0;
         m_redir = 0;
         m_empty = 0;
      end else begin
         if (pcsrc) m_redir++;
         if ((mq.size() == 0) && !stall) m_empty++;
         if (pcsrc) begin
            mq.delete();
            m_pc   = npc;
            m_pend = 1'b0;
         end else begin
            if ((mq.size() != 0) && !stall) void'(mq.pop_front());
            if (m_pend) mq.push_back('{instr: instr_of(m_pend_addr), pc4: m_pend_addr + 32'd4});
            m_pend = exp_req && ready;
            if (m_pend) begin
               m_pend_addr = m_pc;
               m_pc        = m_pc + 32'd4;
            end
         end
      end
      next_cycle();
   endtask

   initial begin
      //          rst pcsrc npc            stall rdy  req addr           vld pc4           zero
      tbl[0]  = '{1, 0, 32'h0,          0, 1,  0, 32'h0,          0, 32'h0,          1};
      tbl[1]  = '{0, 0, 32'h0,          0, 1,  1, 32'h0,          0, 32'h0,          1};
      tbl[2]  = '{0, 0, 32'h0,          0, 1,  1, 32'h4,          0, 32'h0,          0};
      tbl[3]  = '{0, 0, 32'h0,          0, 1,  1, 32'h8,          1, 32'h4,          0};
      tbl[4]  = '{0, 0, 32'h0,          0, 1,  1, 32'hC,          1, 32'h8,          0};
      tbl[5]  = '{0, 1, 32'h100,        0, 1,  0, 32'h10,         1, 32'hC,          0};
      tbl[6]  = '{0, 0, 32'h0,          0, 1,  1, 32'h100,        0, 32'h0,          0};
      tbl[7]  = '{0, 0, 32'h0,          0, 1,  1, 32'h104,        0, 32'h0,          0};
      tbl[8]  = '{0, 0, 32'h0,          0, 1,  1, 32'h108,        1, 32'h104,        0};
      tbl[9]  = '{0, 0, 32'h0,          1, 1,  1, 32'h10C,        1, 32'h108,        0};
      tbl[10] = '{0, 0, 32'h0,          1, 1,  1, 32'h110,        1, 32'h108,        0};
      tbl[11] = '{0, 0, 32'h0,          1, 1,  0, 32'h114,        1, 32'h108,        0};
      tbl[12] = '{0, 0, 32'h0,          1, 1,  0, 32'h114,        1, 32'h108,        0};
      tbl[13] = '{0, 0, 32'h0,          0, 1,  0, 32'h114,        1, 32'h108,        0};
      tbl[14] = '{0, 0, 32'h0,          0, 1,  1, 32'h114,        1, 32'h10C,        0};
      tbl[15] = '{0, 1, 32'hFFFF_FFFC,  0, 1,  0, 32'h118,        1, 32'h110,        0};
      tbl[16] = '{0, 0, 32'h0,          0, 1,  1, 32'hFFFF_FFFC,  0, 32'h0,          0};
      tbl[17] = '{0, 0, 32'h0,          0, 1,  1, 32'h0,          0, 32'h0,          0};
      tbl[18] = '{0, 0, 32'h0,          0, 1,  1, 32'h4,          1, 32'h0,          0};
      tbl[19] = '{0, 0, 32'h0,          0, 1,  1, 32'h8,          1, 32'h4,          0};

      @(posedge Clk);
      #1;

      // Directed vectors: startup stream, redirect with data in flight,
      // fill under stall, drain, and a redirect that wraps the PC
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].pcsrc, tbl[i].npc, tbl[i].stall, tbl[i].ready);
         #2;
         check($sformatf("v%0d_req", i), 32'(IM_Req), 32'(tbl[i].req));
         check($sformatf("v%0d_addr", i), IM_Addr, tbl[i].addr);
         check($sformatf("v%0d_valid", i), 32'(IF_Valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            check($sformatf("v%0d_pc4", i), IF_PC4, tbl[i].pc4);
            check($sformatf("v%0d_instr", i), IF_Instruction, instr_of(tbl[i].pc4 - 32'd4));
         end
         if (tbl[i].zero_head) begin
            check($sformatf("v%0d_zero_instr", i), IF_Instruction, 32'h0);
            check($sformatf("v%0d_zero_pc4", i), IF_PC4, 32'h0);
         end
         next_cycle();
      end

      // Fill under stall, confirm full, drain in order
      model_cycle(1, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) model_cycle(0, 0, 0, 1, 1);
      check("queue_full", 32'(dut.u_queue.o_count), DEPTH);
      for (int i = 0; i < 6; i++) model_cycle(0, 0, 0, 0, 1);

      // Reset while full, then restart with no stale entries
      for (int i = 0; i < 8; i++) model_cycle(0, 0, 0, 1, 1);
      model_cycle(1, 0, 0, 1, 1);
      for (int i = 0; i < 6; i++) model_cycle(0, 0, 0, 0, 1);

      // Ready toggling with random stall and occasional redirects
      for (int i = 0; i < 300; i++) begin
         model_cycle(0, ($urandom_range(15, 0) == 0), $urandom & 32'hFFFF_FFFC,
                     ($urandom_range(1, 0) == 1), ((i % 2) == 0));
      end

      // Fully random traffic including reset pulses
      for (int i = 0; i < 600; i++) begin
         model_cycle(($urandom_range(96, 0) == 0), ($urandom_range(19, 0) == 0),
                     $urandom & 32'hFFFF_FFFC, ($urandom_range(2, 0) == 0),
                     ($urandom_range(3, 0) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
